// File: rtl/arx_pkg.sv
// Shared types and constants for the arx_mix iterative ARX mixing stage.
package arx_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [4:0] ROT [4] = '{5'd7, 5'd9, 5'd13, 5'd18};

  function automatic logic [4:0] rotAmt(input logic [1:0] r);
    return ROT[r];
  endfunction

endpackage

// File: rtl/arx_mix_rotl32.sv
// rotl32: combinational 32-bit rotate-left by a 5-bit amount.
module rotl32
  import arx_pkg::*;
(
  input  logic [WORD_W-1:0] x,
  input  logic [4:0]        k,
  output logic [WORD_W-1:0] o
);

  logic [5:0] rsh;

  // k=0 is short-circuited so the right shift never needs the full word width
  assign rsh = 6'd32 - {1'b0, k};
  assign o   = (k == 5'd0) ? x : ((x << k) | (x >> rsh));

endmodule

// File: rtl/arx_mix.sv
// arx_mix: iterative ARX mixer, one round per cycle, valid/ready on both sides.
// Optional feed-forward of the input pair into the outputs via ARX_MIX_FEEDFWD_EN.
module arx_mix
  import arx_pkg::*;
#(
  parameter int ROUNDS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_a,
  input  logic [WORD_W-1:0] in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_a,
  output logic [WORD_W-1:0] out_b
);

  localparam int RND_W = $clog2(ROUNDS + 1);
  localparam logic [RND_W-1:0] LAST = RND_W'(ROUNDS - 1);

  state_t state, nextState;
  logic [WORD_W-1:0] a, b, sum, rotB;
  logic [RND_W-1:0]  rnd;
  logic [4:0]        rotK;
  logic              accept;

  assign accept = in_valid & in_ready;
  assign sum    = a + b;
  assign rotK   = rotAmt(2'(rnd));

  rotl32 uRot (
    .x(b),
    .k(rotK),
    .o(rotB)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (in_valid) nextState = RUN;
      RUN:     if (rnd == LAST) nextState = DONE;
      DONE:    if (out_ready) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE:    in_ready = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // a/b/rnd only move on acceptance or during RUN, so DONE holds the result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a   <= '0;
      b   <= '0;
      rnd <= '0;
    end else begin
      if (state == IDLE && accept) begin
        a   <= in_a;
        b   <= in_b;
        rnd <= '0;
      end else if (state == RUN) begin
        a   <= sum;
        b   <= rotB ^ sum;
        rnd <= rnd + RND_W'(1);
      end
    end
  end

`ifdef ARX_MIX_FEEDFWD_EN
  logic [WORD_W-1:0] a0, b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a0 <= '0;
      b0 <= '0;
    end else if (state == IDLE && accept) begin
      a0 <= in_a;
      b0 <= in_b;
    end
  end

  assign out_a = a + a0;
  assign out_b = b + b0;
`else
  assign out_a = a;
  assign out_b = b;
`endif

endmodule

// File: tb/tb_arx_mix.sv
// Scoreboard bench for arx_mix: three instances (ROUNDS = 1, 2, 8) checked against
// a loop-based reference model; honours ARX_MIX_FEEDFWD_EN when defined.
module tb_arx_mix;

  localparam int NI = 3;
  localparam int RND [NI] = '{1, 2, 8};

  typedef struct packed {
    logic [1:0]  inst;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        inValid  [NI];
  logic        inReady  [NI];
  logic [31:0] inA      [NI];
  logic [31:0] inB      [NI];
  logic        outValid [NI];
  logic        outReady [NI];
  logic [31:0] outA     [NI];
  logic [31:0] outB     [NI];

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle = 0;
  int   acceptEdge [NI];
  bit   hasAccept  [NI];
  bit   prevOutValid [NI];
  bit   b2bMode = 0;
  logic [63:0] accM;
  int   spacing;
  int   latency;
  exp_t popped;

  arx_mix #(.ROUNDS(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(inValid[0]), .in_ready(inReady[0]), .in_a(inA[0]), .in_b(inB[0]),
    .out_valid(outValid[0]), .out_ready(outReady[0]), .out_a(outA[0]), .out_b(outB[0])
  );

  arx_mix #(.ROUNDS(2)) dut2 (
    .clk(clk), .rst(rst),
    .in_valid(inValid[1]), .in_ready(inReady[1]), .in_a(inA[1]), .in_b(inB[1]),
    .out_valid(outValid[1]), .out_ready(outReady[1]), .out_a(outA[1]), .out_b(outB[1])
  );

  arx_mix #(.ROUNDS(8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(inValid[2]), .in_ready(inReady[2]), .in_a(inA[2]), .in_b(inB[2]),
    .out_valid(outValid[2]), .out_ready(outReady[2]), .out_a(outA[2]), .out_b(outB[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycle <= cycle + 1;

  // Reference: iterate the round rule on whole words, rotating via a doubled word
  function automatic logic [63:0] model(input int rounds, input logic [31:0] ia, input logic [31:0] ib);
    logic [31:0] a, b, s;
    logic [63:0] dbl;
    int rotTab [4];
    rotTab = '{7, 9, 13, 18};
    a = ia;
    b = ib;
    for (int r = 0; r < rounds; r++) begin
      s   = a + b;
      dbl = {b, b} << rotTab[r % 4];
      b   = dbl[63:32] ^ s;
      a   = s;
    end
`ifdef ARX_MIX_FEEDFWD_EN
    a = a + ia;
    b = b + ib;
`endif
    return {a, b};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Acceptance monitor: push the model result for every pair the DUT takes
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < NI; i++) hasAccept[i] = 1'b0;
    end else begin
      for (int i = 0; i < NI; i++) begin
        if (inValid[i] && inReady[i]) begin
          if (hasAccept[i]) begin
            spacing = cycle + 1 - acceptEdge[i];
            checks++;
            if ((b2bMode && spacing != RND[i] + 2) || spacing < RND[i] + 2) begin
              errors++;
              $display("[TB] FAIL spacing inst %0d: got %0d cycles expected %0d", i, spacing, RND[i] + 2);
            end
          end
          acceptEdge[i] = cycle + 1;
          hasAccept[i]  = 1'b1;
          accM = model(RND[i], inA[i], inB[i]);
          sbq.push_back('{inst: 2'(i), a: accM[63:32], b: accM[31:0]});
        end
      end
    end
  end

  // Output monitor: latency on every rising out_valid, scoreboard pop on handshake
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (!rst && outValid[i] && !prevOutValid[i]) begin
        latency = cycle - acceptEdge[i];
        checks++;
        if (!hasAccept[i] || latency != RND[i]) begin
          errors++;
          $display("[TB] FAIL latency inst %0d: got %0d edges expected %0d", i, latency, RND[i]);
        end
      end
      if (!rst && outValid[i] && outReady[i]) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected output inst %0d: got %h/%h expected none", i, outA[i], outB[i]);
        end else begin
          popped = sbq.pop_front();
          checkOutput("sb_inst", 32'(i), 32'(popped.inst));
          checkOutput("sb_out_a", outA[i], popped.a);
          checkOutput("sb_out_b", outB[i], popped.b);
        end
      end
      prevOutValid[i] = outValid[i];
    end
  end

  task automatic applyStimulus(input int i, input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    inValid[i] = 1'b1;
    inA[i] = a;
    inB[i] = b;
    while (!inReady[i] && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!inReady[i]) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept timeout inst %0d: in_ready got 0 expected 1", i);
    end
    @(posedge clk); #1;
    inValid[i] = 1'b0;
    inA[i] = $urandom;
    inB[i] = $urandom;
  endtask

  task automatic waitOutput(input int i);
    int n;
    n = 0;
    while (!outValid[i] && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!outValid[i]) begin
      checks++;
      errors++;
      $display("[TB] FAIL output timeout inst %0d: out_valid got 0 expected 1", i);
    end
  endtask

  task automatic runDirected(input int i, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] ea, input logic [31:0] eb, input string name);
    applyStimulus(i, a, b);
    waitOutput(i);
    checkOutput({name, "_a"}, outA[i], ea);
    checkOutput({name, "_b"}, outB[i], eb);
    @(posedge clk); #1;
    checkOutput({name, "_idle_ready"}, 32'(inReady[i]), 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("drain_empty", 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    logic [63:0] m;
    logic [31:0] ra, rb;
    rst = 1'b1;
    for (int i = 0; i < NI; i++) begin
      inValid[i]  = 1'b0;
      inA[i]      = '0;
      inB[i]      = '0;
      outReady[i] = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      checkOutput("rst_in_ready", 32'(inReady[i]), 32'd1);
      checkOutput("rst_out_valid", 32'(outValid[i]), 32'd0);
      checkOutput("rst_out_a", outA[i], 32'd0);
      checkOutput("rst_out_b", outB[i], 32'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

`ifdef ARX_MIX_FEEDFWD_EN
    runDirected(0, 32'h1, 32'h2, 32'h4, 32'h105, "r1_basic");
    runDirected(1, 32'h1, 32'h2, 32'h107, 32'h20708, "r2_basic");
    runDirected(0, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFF, 32'h81, "r1_wrap1");
    runDirected(0, 32'h0, 32'h80000000, 32'h80000000, 32'h40, "r1_wrap2");
`else
    runDirected(0, 32'h1, 32'h2, 32'h3, 32'h103, "r1_basic");
    runDirected(1, 32'h1, 32'h2, 32'h106, 32'h20706, "r2_basic");
    runDirected(0, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h80, "r1_wrap1");
    runDirected(0, 32'h0, 32'h80000000, 32'h80000000, 32'h80000040, "r1_wrap2");
`endif

    // Random pairs on every instance
    for (int i = 0; i < NI; i++) begin
      for (int k = 0; k < 4; k++) begin
        applyStimulus(i, $urandom, $urandom);
        waitOutput(i);
        @(posedge clk); #1;
      end
    end
    drain();

    // Backpressure on the 8-round instance
    outReady[2] = 1'b0;
    ra = $urandom;
    rb = $urandom;
    m = model(8, ra, rb);
    applyStimulus(2, ra, rb);
    waitOutput(2);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      checkOutput("bp_out_valid", 32'(outValid[2]), 32'd1);
      checkOutput("bp_in_ready", 32'(inReady[2]), 32'd0);
      checkOutput("bp_out_a", outA[2], m[63:32]);
      checkOutput("bp_out_b", outB[2], m[31:0]);
    end
    outReady[2] = 1'b1;
    @(posedge clk); #1;
    outReady[2] = 1'b0;
    checkOutput("bp_release_in_ready", 32'(inReady[2]), 32'd1);
    checkOutput("bp_release_out_valid", 32'(outValid[2]), 32'd0);
    outReady[2] = 1'b1;

    // Reset during round 3 discards the pair
    applyStimulus(2, $urandom, $urandom);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midrst_out_valid", 32'(outValid[2]), 32'd0);
    checkOutput("midrst_out_a", outA[2], 32'd0);
    checkOutput("midrst_out_b", outB[2], 32'd0);
    checkOutput("midrst_in_ready", 32'(inReady[2]), 32'd1);
    sbq.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    ra = $urandom;
    rb = $urandom;
    m = model(8, ra, rb);
    runDirected(2, ra, rb, m[63:32], m[31:0], "postrst");
    drain();

    // Back-to-back with in_valid held and inputs scrambled every cycle
    for (int i = 0; i < NI; i += 2) begin
      b2bMode = 1'b1;
      hasAccept[i] = 1'b0;
      inValid[i] = 1'b1;
      for (int c = 0; c < 3 * (RND[i] + 2) + 2; c++) begin
        inA[i] = $urandom;
        inB[i] = $urandom;
        @(posedge clk); #1;
      end
      inValid[i] = 1'b0;
      b2bMode = 1'b0;
      drain();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
